// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: aluop and alusel codes, bus
// widths and the multiply-accumulate FSM state type.
package ex_stage_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned AluOpBus     = 8;
  localparam int unsigned AluSelBus    = 3;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } madd_state_e;

  function automatic logic is_madd_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/ex_mult.sv
// Combinational DATA_W x DATA_W -> 2*DATA_W multiplier. Both operands are
// extended to full product width (sign or zero) so a single unsigned
// multiply yields the correct low 2*DATA_W bits in either mode.
module ex_mult #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                signed_i,
  output logic [2*DATA_W-1:0] prod_o
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // extend operands per signedness, then multiply at full width
  always_comb begin
    a_ext  = signed_i ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
    b_ext  = signed_i ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
    prod_o = a_ext * b_ext;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU classes, HI/LO forwarding and writes, and
// a two-cycle multiply-accumulate sequence that stalls the pipe for one cycle.
// Optional feature macro: EX_MADD_EN (madd/msub FSM + hilo_temp). Without it,
// MADD/MADDU/MSUB/MSUBU behave as NOP and stallreq_o is tied low.
//
// state  | meaning
// S_IDLE | no accumulate in flight; madd-class op registers product, stalls
// S_ACC  | product held in hilo_temp; same op completes the HI/LO update
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              mem_whilo_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic              wb_whilo_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  localparam int SHAMT_W = $clog2(DATA_W);

  // the accumulate sequence is hard-wired to one stall cycle
  generate
    if (ACC_CYCLES != 2) begin : g_acc_cycles_illegal
      $error("ex_stage: ACC_CYCLES must be 2");
    end
  endgenerate

  logic [DATA_W-1:0]   fwd_hi;
  logic [DATA_W-1:0]   fwd_lo;
  logic                mult_signed;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   result;
  logic [SHAMT_W-1:0]  shamt;
  logic                whilo_c;
  logic [DATA_W-1:0]   hi_c;
  logic [DATA_W-1:0]   lo_c;
  logic                madd_whilo;
  logic                madd_stall;
  logic [2*DATA_W-1:0] madd_hilo;

  // youngest pending HI/LO write wins
  always_comb begin
    if (mem_whilo_i) begin
      fwd_hi = mem_hi_i;
      fwd_lo = mem_lo_i;
    end else if (wb_whilo_i) begin
      fwd_hi = wb_hi_i;
      fwd_lo = wb_lo_i;
    end else begin
      fwd_hi = hi_i;
      fwd_lo = lo_i;
    end
  end

  assign mult_signed = (aluop_i == EXE_MUL_OP)  || (aluop_i == EXE_MULT_OP) ||
                       (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);

  ex_mult #(.DATA_W(DATA_W)) u_mult (
    .a_i     (reg1_i),
    .b_i     (reg2_i),
    .signed_i(mult_signed),
    .prod_o  (prod)
  );

  assign shamt = reg1_i[SHAMT_W-1:0];

  // write-back result selected by result class, then by operation
  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << shamt;
          EXE_SRL_OP: result = reg2_i >> shamt;
          EXE_SRA_OP: result = $signed(reg2_i) >>> shamt;
          default:    result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: result = fwd_hi;
          EXE_MFLO_OP: result = fwd_lo;
          default:     result = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADDU_OP: result = reg1_i + reg2_i;
          EXE_SUBU_OP: result = reg1_i - reg2_i;
          EXE_SLT_OP:  result = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          EXE_SLTU_OP: result = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
          default:     result = '0;
        endcase
      end
      EXE_RES_MUL: begin
        if (aluop_i == EXE_MUL_OP) result = prod[DATA_W-1:0];
      end
      default: result = '0;
    endcase
  end

`ifdef EX_MADD_EN
  madd_state_e         state_q, state_d;
  logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
  logic                madd_sub;

  assign madd_sub = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);

  // accumulate state and held product
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hilo_temp_q <= '0;
    end else begin
      state_q     <= state_d;
      hilo_temp_q <= hilo_temp_d;
    end
  end

  // next state and accumulate outputs; a non-madd op in S_ACC is a flush
  always_comb begin
    state_d     = state_q;
    hilo_temp_d = hilo_temp_q;
    madd_whilo  = 1'b0;
    madd_stall  = 1'b0;
    madd_hilo   = '0;
    case (state_q)
      S_IDLE: begin
        if (is_madd_op(aluop_i)) begin
          hilo_temp_d = prod;
          madd_stall  = 1'b1;
          state_d     = S_ACC;
        end
      end
      S_ACC: begin
        state_d     = S_IDLE;
        hilo_temp_d = '0;
        if (is_madd_op(aluop_i)) begin
          madd_whilo = 1'b1;
          madd_hilo  = madd_sub ? ({fwd_hi, fwd_lo} - hilo_temp_q)
                                : ({fwd_hi, fwd_lo} + hilo_temp_q);
        end
      end
      default: begin
        state_d     = S_IDLE;
        hilo_temp_d = '0;
      end
    endcase
  end
`else
  // clock only feeds the accumulate FSM; keep it visibly consumed
  logic unused_clk;
  assign unused_clk = clk;
  assign madd_whilo = 1'b0;
  assign madd_stall = 1'b0;
  assign madd_hilo  = '0;
`endif

  // HI/LO write request
  always_comb begin
    whilo_c = 1'b0;
    hi_c    = '0;
    lo_c    = '0;
    case (aluop_i)
      EXE_MTHI_OP: begin
        whilo_c = 1'b1;
        hi_c    = reg1_i;
        lo_c    = fwd_lo;
      end
      EXE_MTLO_OP: begin
        whilo_c = 1'b1;
        hi_c    = fwd_hi;
        lo_c    = reg1_i;
      end
      EXE_MULT_OP, EXE_MULTU_OP: begin
        whilo_c      = 1'b1;
        {hi_c, lo_c} = prod;
      end
      default: begin
        whilo_c      = madd_whilo;
        {hi_c, lo_c} = madd_hilo;
      end
    endcase
  end

  assign wd_o       = rst ? wd_i       : '0;
  assign wreg_o     = rst ? wreg_i     : 1'b0;
  assign wdata_o    = rst ? result     : '0;
  assign whilo_o    = rst ? whilo_c    : 1'b0;
  assign hi_o       = rst ? hi_c       : '0;
  assign lo_o       = rst ? lo_c       : '0;
  assign stallreq_o = rst ? madd_stall : 1'b0;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases followed by randomized operations,
// compared against a behavioural model that tracks a pending madd product.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  ex_stage #(.DATA_W(32), .ACC_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .mem_whilo_i(mem_whilo_i),
    .mem_hi_i   (mem_hi_i),
    .mem_lo_i   (mem_lo_i),
    .wb_whilo_i (wb_whilo_i),
    .wb_hi_i    (wb_hi_i),
    .wb_lo_i    (wb_lo_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef EX_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // model state: a madd-class product waiting for its completing cycle
  bit          pend;
  logic [63:0] pend_prod;
  logic [7:0]  pend_op;
  bit          next_pend;
  logic [63:0] next_prod;
  logic [7:0]  next_op;

  localparam int NOPS    = 23;
  localparam int NNONMAD = 19;
  logic [7:0] ops [NOPS] = '{
    EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
    EXE_SRA_OP, EXE_MFHI_OP, EXE_MTHI_OP, EXE_MFLO_OP, EXE_MTLO_OP,
    EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MULT_OP,
    EXE_MULTU_OP, EXE_MUL_OP, 8'hFF,
    EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};

  function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [2:0] op_class(input logic [7:0] op);
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP: return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            return EXE_RES_SHIFT;
      EXE_MFHI_OP, EXE_MFLO_OP:                      return EXE_RES_MOVE;
      EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP: return EXE_RES_ARITH;
      EXE_MUL_OP:                                    return EXE_RES_MUL;
      default:                                       return EXE_RES_NOP;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] fh, input logic [31:0] fl);
    logic [31:0] v;
    logic [63:0] p;
    logic [4:0]  sh;
    sh = a[4:0];
    v  = 32'h0;
    case (op)
      EXE_AND_OP:  v = a & b;
      EXE_OR_OP:   v = a | b;
      EXE_XOR_OP:  v = a ^ b;
      EXE_NOR_OP:  v = ~(a | b);
      EXE_SLL_OP:  v = b << sh;
      EXE_SRL_OP:  v = b >> sh;
      EXE_SRA_OP:  v = 32'($signed(b) >>> sh);
      EXE_MFHI_OP: v = fh;
      EXE_MFLO_OP: v = fl;
      EXE_ADDU_OP: v = a + b;
      EXE_SUBU_OP: v = a - b;
      EXE_SLT_OP:  v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: v = (a < b) ? 32'd1 : 32'd0;
      EXE_MUL_OP: begin
        p = prod64(a, b, 1'b1);
        v = p[31:0];
      end
      default: v = 32'h0;
    endcase
    return (sel == op_class(op) && sel != EXE_RES_NOP) ? v : 32'h0;
  endfunction

  // compare all outputs against the model for the inputs currently applied
  task automatic eval_check();
    logic [31:0] fh, fl, e_wdata;
    logic [63:0] e_hilo, p;
    bit          e_whilo, e_stall;
    bit          sgn, sub;
    next_pend = 1'b0;
    next_prod = 64'h0;
    next_op   = 8'h0;
    if (!rst) begin
      check("rst_wd", wd_o, 0);
      check("rst_wreg", wreg_o, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_whilo", whilo_o, 0);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);
      check("rst_stall", stallreq_o, 0);
      return;
    end
    fh = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    fl = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
    e_wdata = ref_result(aluop_i, alusel_i, reg1_i, reg2_i, fh, fl);
    e_whilo = 1'b0;
    e_stall = 1'b0;
    e_hilo  = 64'h0;
    case (aluop_i)
      EXE_MTHI_OP:  begin e_whilo = 1'b1; e_hilo = {reg1_i, fl}; end
      EXE_MTLO_OP:  begin e_whilo = 1'b1; e_hilo = {fh, reg1_i}; end
      EXE_MULT_OP:  begin e_whilo = 1'b1; e_hilo = prod64(reg1_i, reg2_i, 1'b1); end
      EXE_MULTU_OP: begin e_whilo = 1'b1; e_hilo = prod64(reg1_i, reg2_i, 1'b0); end
      EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
        if (MaddEn) begin
          sgn = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
          sub = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
          if (!pend) begin
            p         = prod64(reg1_i, reg2_i, sgn);
            e_stall   = 1'b1;
            next_pend = 1'b1;
            next_prod = p;
            next_op   = aluop_i;
          end else begin
            e_whilo = 1'b1;
            e_hilo  = sub ? ({fh, fl} - pend_prod) : ({fh, fl} + pend_prod);
          end
        end
      end
      default: ;
    endcase
    check("wd", wd_o, wd_i);
    check("wreg", wreg_o, wreg_i);
    check("wdata", wdata_o, e_wdata);
    check("whilo", whilo_o, e_whilo);
    check("stall", stallreq_o, e_stall);
    if (e_whilo) begin
      check("hi", hi_o, e_hilo[63:32]);
      check("lo", lo_o, e_hilo[31:0]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    pend      = next_pend;
    pend_prod = next_prod;
    pend_op   = next_op;
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    pend = 1'b0; pend_prod = 64'h0; pend_op = 8'h0;
    rst = 1'b0;
    set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'd5, 32'd7);
    wd_i = 5'd9; wreg_i = 1'b1;
    hi_i = 32'h0; lo_i = 32'h0;
    mem_whilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
    wb_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;

    // reset held for two edges
    for (int i = 0; i < 2; i++) begin
      #3;
      eval_check();
      advance();
    end
    rst = 1'b1;
    #3;
    check("addu_after_rst", wdata_o, 32'd12);
    eval_check();
    advance();

    set_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
    #3; check("sra_fill", wdata_o, 32'hF800_0000); eval_check(); advance();
    set_op(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
    #3; check("slt_neg", wdata_o, 32'd1); eval_check(); advance();
    set_op(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
    #3; check("sltu_big", wdata_o, 32'd0); eval_check(); advance();

    set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    hi_i = 32'd1; wb_whilo_i = 1'b1; wb_hi_i = 32'd2; mem_whilo_i = 1'b1; mem_hi_i = 32'd3;
    #3; check("mfhi_mem", wdata_o, 32'd3); eval_check(); advance();
    mem_whilo_i = 1'b0;
    #3; check("mfhi_wb", wdata_o, 32'd2); eval_check(); advance();
    wb_whilo_i = 1'b0; hi_i = 32'h0; lo_i = 32'd10;

    // MADD -1 * 2 onto 0:10
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2);
    #3; check("madd_c1_stall", stallreq_o, MaddEn); check("madd_c1_whilo", whilo_o, 0);
    eval_check(); advance();
    #3;
    check("madd_c2_whilo", whilo_o, MaddEn);
    check("madd_c2_stall", stallreq_o, 0);
    if (MaddEn) begin
      check("madd_c2_hi", hi_o, 32'd0);
      check("madd_c2_lo", lo_o, 32'd8);
    end
    eval_check(); advance();

    // MSUBU onto 0:0
    lo_i = 32'h0;
    set_op(EXE_MSUBU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2);
    #3; eval_check(); advance();
    #3;
    if (MaddEn) check("msubu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0002);
    eval_check(); advance();

    // MADD flushed by OR in the following cycle, then MADD restarts from idle
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4);
    #3; eval_check(); advance();
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0, 32'h0F);
    #3;
    check("flush_whilo", whilo_o, 0);
    check("flush_or", wdata_o, 32'hFF);
    eval_check(); advance();
    set_op(EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4);
    #3; check("restart_stall", stallreq_o, MaddEn); eval_check(); advance();
    #3; eval_check(); advance();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] op;
      rst = ($urandom_range(39) != 0);
      if (pend && $urandom_range(2) != 0) op = pend_op;
      else if (pend) op = ops[$urandom_range(NNONMAD - 1)];
      else op = ops[$urandom_range(NOPS - 1)];
      set_op(op, ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : op_class(op),
             rand_word(), rand_word());
      wd_i = 5'($urandom); wreg_i = 1'($urandom);
      hi_i = rand_word(); lo_i = rand_word();
      mem_whilo_i = 1'($urandom); mem_hi_i = rand_word(); mem_lo_i = rand_word();
      wb_whilo_i  = 1'($urandom); wb_hi_i  = rand_word(); wb_lo_i  = rand_word();
      #3;
      eval_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
